dbus_timer: RTL
===============

# dbus_timer

Memory-mapped timer peripheral that acts as a responder on the RV32I core's single-cycle data-memory port. It serves loads and stores to five 32-bit registers. It runs a prescaled 32-bit up-counter with compare match, optional auto-reload, sticky status flags and a level interrupt. The top level places it beside the data memory and steers it through an address-decode select; it returns read data in the same cycle, so no stall is needed.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous assert, active-low; clears all state.
- d_sel  input  1  peripheral select from top-level address decode.
- d_we  input  1  store strobe from core; write happens at edge when d_sel & d_we.
- daddr  input  7  byte address; daddr[4:2] selects register, daddr[1:0] ignored.
- dwdata  input  32  store data, always full-word.
- drdata  output  32  load data, combinational from d_sel/daddr and current register state.
- irq  output  1  level interrupt = CTRL.IRQ_EN & STATUS.MATCH, registered-state derived.

## Operation
- Register map (daddr[4:2]):
  - 0 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN, other bits read 0.
  - 1 PRESCALE: [15:0] P, upper bits read 0.
  - 2 COUNT: 32-bit counter, R/W.
  - 3 COMPARE: 32-bit, R/W.
  - 4 STATUS: [0] MATCH, [1] OVF; sticky; write-1-to-clear per bit.
  - 5-7: unmapped, read 0, writes ignored.
- The 16-bit prescale counter psc is internal. While EN=1, psc increments each cycle. When psc==P, a tick is issued and psc returns to 0. While EN=0, psc is held at 0.
- On a tick:
  - If COUNT==COMPARE, MATCH is set.
  - If COUNT==COMPARE and AUTO_RELOAD=1, COUNT becomes 0.
  - Otherwise COUNT becomes COUNT+1, mod 2^32. The 0xFFFFFFFF→0 wrap sets OVF.
- A store to COUNT loads dwdata and clears psc. That cycle's tick is suppressed: no increment and no match evaluation.
- A store to PRESCALE or CTRL does not clear psc, except that a CTRL store with EN=0 forces psc to 0.
- drdata is 0 when d_sel=0. Reads have no side effects.
- Reset: CTRL, PRESCALE, COUNT, COMPARE, STATUS and psc are all 0. Outputs are drdata=0 and irq=0.

## Timing
- Read latency is 0 cycles: drdata follows daddr combinationally.
- A stored value is visible on drdata in the cycle after the write edge.
- With EN written 1 at edge k and prescale P:
  - first COUNT increment at edge k+P+1;
  - subsequent increments every P+1 cycles.
  - P=0 gives one increment per cycle.
- MATCH sets at the tick edge where COUNT==COMPARE held beforehand. irq rises in the following cycle, from registered state only, with no combinational path from the bus.
- Simultaneous events:
  - STATUS W1C in the same cycle as a hardware set of the same bit: the set wins, so the bit stays 1.
  - COUNT store in the same cycle as a tick: the store wins.
  - A store while d_sel=0 is ignored entirely.
- Asserting rst mid-count clears everything immediately, independent of clk. The first tick after release needs EN rewritten.

## Test plan
- Reset and idle:
  - rst low with random bus traffic → drdata=0, irq=0.
  - After release, read all five registers → all 0.
  - Read offset 0x18 → 0.
- Prescale rate:
  - PRESCALE=3, COUNT=0, CTRL=0x1 → COUNT reads 1, 2, 3 at 4, 8, 12 cycles after the EN write edge.
- Match with auto-reload and irq:
  - COMPARE=5, P=0, CTRL=0x7 → COUNT sequence 0..5, 0, 1…
  - MATCH=1 after the tick where COUNT was 5; irq high the next cycle.
  - W1C STATUS=0x1 → MATCH=0 and irq=0 (until the next match).
- Overflow:
  - COUNT=0xFFFFFFFE, COMPARE=0x10, P=0, CTRL=0x1 → COUNT goes 0xFFFFFFFF then 0; OVF=1; MATCH=0; irq=0.
- Collisions:
  - STATUS W1C in the same cycle MATCH is set → MATCH stays 1.
  - COUNT=0x100 stored in a tick cycle → reads exactly 0x100 next cycle and does not match an equal COMPARE that cycle.
- Select gating and mid-run reset:
  - d_sel=0 with d_we=1 to COMPARE → unchanged.
  - Assert rst while counting at COUNT=0x20 → all registers 0 immediately; irq drops without a clock edge.

Source files
------------

// File: rtl/dbus_timer.sv
// Memory-mapped timer on the core's single-cycle data port: prescaled 32-bit
// up-counter with compare match, optional auto-reload, sticky flags and a level irq.
module dbus_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_sel,
  input  logic        d_we,
  input  logic [6:0]  daddr,
  input  logic [31:0] dwdata,
  output logic [31:0] drdata,
  output logic        irq
);

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_COMPARE  = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;

  // ctrl bits: [0] enable, [1] auto-reload, [2] irq enable
  logic [2:0]  ctrl_q, ctrl_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] psc_q, psc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        match_q, match_d;
  logic        ovf_q, ovf_d;

  logic [2:0]  reg_idx;
  logic        wr_en;
  logic        wr_ctrl, wr_presc, wr_count, wr_compare, wr_status;
  logic        tick;
  logic        cmp_hit;
  logic        match_set, ovf_set;

  assign reg_idx    = daddr[4:2];
  assign wr_en      = d_sel & d_we;
  assign wr_ctrl    = wr_en && (reg_idx == REG_CTRL);
  assign wr_presc   = wr_en && (reg_idx == REG_PRESCALE);
  assign wr_count   = wr_en && (reg_idx == REG_COUNT);
  assign wr_compare = wr_en && (reg_idx == REG_COMPARE);
  assign wr_status  = wr_en && (reg_idx == REG_STATUS);

  assign tick    = ctrl_q[0] && (psc_q == presc_q);
  assign cmp_hit = (count_q == compare_q);

  always_comb begin
    ctrl_d    = ctrl_q;
    presc_d   = presc_q;
    count_d   = count_q;
    compare_d = compare_q;
    match_set = 1'b0;
    ovf_set   = 1'b0;

    if (!ctrl_q[0]) begin
      psc_d = '0;
    end else if (tick) begin
      psc_d = '0;
    end else begin
      psc_d = psc_q + 16'd1;
    end

    // A software load of COUNT takes precedence over the tick in the same cycle.
    if (tick && !wr_count) begin
      match_set = cmp_hit;
      if (cmp_hit && ctrl_q[1]) begin
        count_d = '0;
      end else begin
        count_d = count_q + 32'd1;
        ovf_set = &count_q;
      end
    end

    if (wr_ctrl) begin
      ctrl_d = dwdata[2:0];
      if (!dwdata[0]) begin
        psc_d = '0;
      end
    end
    if (wr_presc) begin
      presc_d = dwdata[15:0];
    end
    if (wr_count) begin
      count_d = dwdata;
      psc_d   = '0;
    end
    if (wr_compare) begin
      compare_d = dwdata;
    end

    // Hardware set beats a same-cycle write-1-to-clear.
    match_d = (match_q & ~(wr_status & dwdata[0])) | match_set;
    ovf_d   = (ovf_q   & ~(wr_status & dwdata[1])) | ovf_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q    <= '0;
      presc_q   <= '0;
      psc_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      match_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      presc_q   <= presc_d;
      psc_q     <= psc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    drdata = '0;
    if (d_sel) begin
      case (reg_idx)
        REG_CTRL:     drdata = {29'd0, ctrl_q};
        REG_PRESCALE: drdata = {16'd0, presc_q};
        REG_COUNT:    drdata = count_q;
        REG_COMPARE:  drdata = compare_q;
        REG_STATUS:   drdata = {30'd0, ovf_q, match_q};
        default:      drdata = '0;
      endcase
    end
  end

  // Derived only from flops, so the bus has no combinational path to irq.
  assign irq = ctrl_q[2] & match_q;

endmodule
